// File: rtl/bist_pkg.sv
// ----------------------------------------------------------------------------
// bist_pkg
//   Shared types for the BIST datapath: the response-analyser controller
//   states and the pattern-generator LFSR operating modes.
//   No ports; import with "import bist_pkg::*;".
// ----------------------------------------------------------------------------
package bist_pkg;

   // Compaction controller states for the MISR response analyser
   typedef enum logic [1:0] {
      IDLE,
      COMPACT,
      DONE
   } misr_state_t;

   // Operating modes of the LFSR pattern generator on the stimulus side
   typedef enum logic [1:0] {
      LFSR_HOLD,
      LFSR_SEED,
      LFSR_RUN
   } lfsr_mode_t;

endpackage

// File: rtl/misr_core.sv
// ----------------------------------------------------------------------------
// misr_core
//   Purely combinational next-state function of a multiple-input signature
//   register. The register shifts towards the MSB, the MSB wraps into stage 0
//   and is XORed into every stage whose POLY bit is set, and the input vector
//   (zero-extended) is XORed into the low stages.
//   Ports:
//     sig      in  WIDTH  current signature
//     data     in  IN_W   response vector to fold in
//     next_sig out WIDTH  signature after folding in data
// ----------------------------------------------------------------------------
module misr_core #(
   parameter int               WIDTH = 16,
   parameter int               IN_W  = 8,
   parameter logic [WIDTH-1:0] POLY  = 16'h1021
) (
   input  logic [WIDTH-1:0] sig,
   input  logic [IN_W-1:0]  data,
   output logic [WIDTH-1:0] next_sig
);

   logic [WIDTH-1:0] data_ext;

   // Stage 0 always receives the MSB, so POLY bit 0 never takes part;
   // the upper stages pick up the MSB only where their tap is set.
   always_comb begin
      data_ext             = '0;
      data_ext[IN_W-1:0]   = data;
      next_sig             = '0;
      next_sig[0]          = sig[WIDTH-1] ^ data_ext[0];
      for (int i = 1; i < WIDTH; i++) begin
         next_sig[i] = sig[i-1] ^ (POLY[i] & sig[WIDTH-1]) ^ data_ext[i];
      end
   end

endmodule

// File: rtl/bist_misr_ctrl.sv
// ----------------------------------------------------------------------------
// bist_misr_ctrl
//   MISR response analyser with its own compaction controller. A start pulse
//   seeds the signature, then exactly NUM_VECTORS valid-qualified vectors are
//   folded in; on the terminal vector the new signature is compared against
//   the golden value and the result is held until the next start.
//   Ports:
//     clock      in  1       rising-edge clock
//     reset      in  1       asynchronous active-high reset
//     start      in  1       pulse that begins a run (IDLE or DONE only)
//     data_valid in  1       data_in holds a response vector this cycle
//     data_in    in  IN_W    response vector
//     golden     in  WIDTH   expected final signature
//     signature  out WIDTH   current MISR contents
//     busy       out 1       compaction in progress
//     done       out 1       run finished, pass is meaningful
//     pass       out 1       final signature matched golden
//     vec_count  out CW      vectors accepted in the current run
// ----------------------------------------------------------------------------
module bist_misr_ctrl
   import bist_pkg::*;
#(
   parameter int               WIDTH       = 16,
   parameter int               IN_W        = 8,
   parameter logic [WIDTH-1:0] POLY        = 16'h1021,
   parameter logic [WIDTH-1:0] SEED        = '0,
   parameter int               NUM_VECTORS = 256,
   localparam int              CW          = $clog2(NUM_VECTORS + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             data_valid,
   input  logic [IN_W-1:0]  data_in,
   input  logic [WIDTH-1:0] golden,
   output logic [WIDTH-1:0] signature,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CW-1:0]    vec_count
);

   localparam logic [CW-1:0] LAST_COUNT = CW'(NUM_VECTORS - 1);

   misr_state_t      state;
   logic [WIDTH-1:0] next_sig;

   misr_core #(
      .WIDTH (WIDTH),
      .IN_W  (IN_W),
      .POLY  (POLY)
   ) u_misr (
      .sig      (signature),
      .data     (data_in),
      .next_sig (next_sig)
   );

   // Controller, vector counter and comparator in one registered block so
   // that busy/done/pass all change on the same edge as the signature.
   // The comparison uses next_sig rather than signature so the verdict is
   // ready on the very edge that absorbs the terminal vector. IDLE and DONE
   // share the reload path, which is what allows back-to-back runs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         signature <= '0;
         vec_count <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= COMPACT;
                  signature <= SEED;
                  vec_count <= '0;
                  pass      <= 1'b0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end
            end
            COMPACT: begin
               if (data_valid) begin
                  signature <= next_sig;
                  vec_count <= vec_count + CW'(1);
                  if (vec_count == LAST_COUNT) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (next_sig == golden);
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/bist_misr_ctrl.md
# bist_misr_ctrl

Parametrised multiple-input signature register with its own compaction controller, for use as the response analyser in the BIST datapath. It compacts a fixed number of valid response vectors, up to `IN_W` bits wide, into a `WIDTH`-bit signature, then compares the result against a golden signature and reports pass/fail. It succeeds the fixed 4-bit/2-input MISR by adding:
- configurable width and polynomial,
- seeding,
- valid-qualified sampling,
- vector counting,
- on-chip signature comparison.

## Interface
- `WIDTH`, 16: signature width; must be at least 2.
- `IN_W`, 8: response vector width; must satisfy 1 ≤ `IN_W` ≤ `WIDTH`.
- `POLY`, 16'h1021: feedback taps; bit i (1 ≤ i ≤ `WIDTH`-1) XORs `sig[WIDTH-1]` into stage i. Bit 0 is ignored because stage 0 feedback is implicit.
- `SEED`, 0: value loaded into the signature on `start`.
- `NUM_VECTORS`, 256: valid vectors compacted per run; must be at least 1.
- `clock` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: single-cycle pulse that begins a run.
- `data_valid` in 1: `data_in` is a response vector this cycle.
- `data_in` in `IN_W`: response vector.
- `golden` in `WIDTH`: expected signature; must be stable from the last accepted vector until `done`.
- `signature` out `WIDTH`: current MISR contents.
- `busy` out 1: high in COMPACT.
- `done` out 1: high in DONE.
- `pass` out 1: comparison result; meaningful only while `done` is high.
- `vec_count` out `$clog2(NUM_VECTORS+1)`: number of vectors accepted in the current run.

## Operation
States: IDLE, COMPACT, DONE.
- IDLE:
  - `start` → COMPACT; `signature`←`SEED`, `vec_count`←0, `pass`←0.
  - `data_valid` is ignored.
- COMPACT:
  - Each cycle with `data_valid`=1, update the MISR and increment `vec_count`.
  - `data_valid`=0 holds all state.
  - `start` is ignored in this state.
- MISR update (s = `signature`, d = `data_in` zero-extended to `WIDTH`):
  - next[0] = s[W-1] ^ d[0]
  - next[i] = s[i-1] ^ (`POLY`[i] & s[W-1]) ^ d[i], for 1 ≤ i < W
- Terminal vector: the accepted vector that brings `vec_count` to `NUM_VECTORS`. On that edge:
  - state → DONE;
  - `pass` ← (next == `golden`), registered from the new signature.
- DONE:
  - `signature`, `pass` and `vec_count` hold.
  - `start` → COMPACT with the same reload as from IDLE (back-to-back runs allowed).
  - No other exit.
- `reset` (at any time, including mid-run): state IDLE; `signature`=0, `vec_count`=0, `busy`=0, `done`=0, `pass`=0. Reset does not load `SEED`; `SEED` is loaded only on `start`.

## Timing
- `start` sampled at edge t: `busy`=1 and `signature`=`SEED` after t.
- The first vector can be accepted at edge t+1.
- Compaction latency is one cycle per accepted vector; there is no pipeline.
- `done` and `pass` become valid at the same edge as the terminal vector's update, so `busy` falls and `done` rises together.
- A run with no gaps takes `NUM_VECTORS`+1 cycles from `start` to `done`.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- The state encoding enum (IDLE/COMPACT/DONE) goes in the shared BIST package `bist_pkg`, alongside the LFSR pattern-generator types.
- One sub-module, `misr_core`: the combinational next-signature function, parametrised by `WIDTH`, `IN_W` and `POLY`. It is reusable by the pattern-generator side.
- The FSM, counter and comparator stay in `bist_misr_ctrl`.

## Test plan
All scenarios use `WIDTH`=4, `IN_W`=2, `POLY`=4'b0010, `SEED`=0, `NUM_VECTORS`=4 unless noted.
- Basic signature: `start`, then vectors 01, 01, 10, 11 on consecutive cycles, `golden`=4'b1011 → signatures 0001, 0011, 0100, 1011; `done`=1 and `pass`=1 exactly at the fourth update; `vec_count`=4.
- Valid gaps: the same four vectors with idle cycles between them (`data_valid`=0, `data_in`=11) → identical final signature 4'b1011; `signature` is unchanged during the gaps.
- Fail detection: the same run with `golden`=4'b1010 → `done`=1, `pass`=0. Then pulse `start` in DONE → `busy`=1, `signature`=0, `vec_count`=0 the next cycle.
- Feedback path: `NUM_VECTORS`=5, vectors 01, 01, 10, 11, 00 → fifth signature 4'b0101, which exercises the `POLY` tap on stage 1.
- Reset mid-run: assert `reset` asynchronously after two accepted vectors → all outputs zero immediately and state IDLE; `data_valid` is ignored until the next `start`.
- Ignored inputs: `start` during COMPACT and `data_valid` during IDLE → no change in state, `signature` or `vec_count`.
